// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: sequential/branch/jump/return next-PC selection with a
// circular return-address stack, registered flush (kill) and sticky RAS error flag.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [15:0] branch_target,
    input  logic [15:0] jump_target,
    input  logic        call,
    input  logic [15:0] return_addr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus1,
    output logic        kill,
    output logic        ras_empty,
    output logic        ras_err
);

    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam logic [PtrW-1:0] PtrMax  = PtrW'(RAS_DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        SrcSeq    = 2'b00,
        SrcBranch = 2'b01,
        SrcJump   = 2'b10,
        SrcRet    = 2'b11
    } pc_src_e;

    logic [15:0]     pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            err_q, err_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;  // next free slot; when full, the oldest entry
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_inc, pop_ptr;
    logic            push;
    logic [15:0]     ras_q [RAS_DEPTH];

    assign pc_plus1   = pc_q + 16'd1;
    assign ras_empty  = (count_q == '0);
    assign pc         = pc_q;
    assign kill       = kill_q;
    assign ras_err    = err_q;
    assign wr_ptr_inc = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
    assign pop_ptr    = (wr_ptr_q == '0) ? PtrMax : wr_ptr_q - PtrW'(1);

    // Next-PC selection and RAS bookkeeping; redirects win over stall.
    always_comb begin
        pc_d     = pc_q;
        kill_d   = 1'b0;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push     = 1'b0;
        case (pc_src_e'(pc_src))
            SrcBranch: begin
                pc_d   = branch_target;
                kill_d = 1'b1;
            end
            SrcJump: begin
                pc_d   = jump_target;
                kill_d = 1'b1;
                if (call) begin
                    push     = 1'b1;
                    wr_ptr_d = wr_ptr_inc;
                    // Full stack: oldest entry is overwritten, count stays saturated.
                    if (count_q == CntFull) err_d = 1'b1;
                    else                    count_d = count_q + CntW'(1);
                end
            end
            SrcRet: begin
                if (!ras_empty) begin
                    pc_d     = ras_q[pop_ptr];
                    kill_d   = 1'b1;
                    wr_ptr_d = pop_ptr;
                    count_d  = count_q - CntW'(1);
                end else begin
                    // Underflow demotes the cycle to a plain sequential fetch.
                    err_d = 1'b1;
                    if (!stall) pc_d = pc_plus1;
                end
            end
            default: begin
                if (!stall) pc_d = pc_plus1;
            end
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            kill_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            kill_q   <= kill_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // RAS storage; a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (!reset && push) ras_q[wr_ptr_q] <= return_addr;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (RESET_PC=0000, RAS_DEPTH=4).
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_src;
    logic [15:0] branch_target;
    logic [15:0] jump_target;
    logic        call;
    logic [15:0] return_addr;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        kill;
    logic        ras_empty;
    logic        ras_err;

    int n_pass;
    int n_total;

    pc_fetch_unit #(
        .RESET_PC (16'h0000),
        .RAS_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .jump_target  (jump_target),
        .call         (call),
        .return_addr  (return_addr),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .kill         (kill),
        .ras_empty    (ras_empty),
        .ras_err      (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic stl, input logic [1:0] src,
                         input logic [15:0] bt, input logic [15:0] jt, input logic cl,
                         input logic [15:0] ra);
        reset = rst; stall = stl; pc_src = src; branch_target = bt;
        jump_target = jt; call = cl; return_addr = ra;
    endtask

    task automatic test_reset();
        drive(1, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        step();
        n_total++; if (pc !== 16'h0000) $display("FAIL reset_pc got %h want 0000", pc); else n_pass++;
        n_total++; if (kill !== 1'b0) $display("FAIL reset_kill got %b want 0", kill); else n_pass++;
        n_total++; if (ras_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", ras_empty); else n_pass++;
        n_total++; if (ras_err !== 1'b0) $display("FAIL reset_err got %b want 0", ras_err); else n_pass++;
        n_total++; if (pc_plus1 !== 16'h0001) $display("FAIL reset_plus1 got %h want 0001", pc_plus1); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
            step();
            n_total++; if (pc !== 16'(i)) $display("FAIL seq_pc[%0d] got %h want %h", i, pc, 16'(i)); else n_pass++;
            n_total++; if (kill !== 1'b0) $display("FAIL seq_kill[%0d] got %b want 0", i, kill); else n_pass++;
        end
    endtask

    task automatic test_stall_branch();
        // pc is 0005 here
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 2'b00, 16'h0, 16'h0, 0, 16'h0);
            step();
            n_total++; if (pc !== 16'h0005) $display("FAIL stall_pc[%0d] got %h want 0005", i, pc); else n_pass++;
            n_total++; if (kill !== 1'b0) $display("FAIL stall_kill[%0d] got %b want 0", i, kill); else n_pass++;
        end
        drive(0, 1, 2'b01, 16'h0040, 16'h0, 0, 16'h0);
        step();
        n_total++; if (pc !== 16'h0040) $display("FAIL branch_pc got %h want 0040", pc); else n_pass++;
        n_total++; if (kill !== 1'b1) $display("FAIL branch_kill got %b want 1", kill); else n_pass++;
        drive(0, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        step();
        n_total++; if (pc !== 16'h0041) $display("FAIL after_branch_pc got %h want 0041", pc); else n_pass++;
        n_total++; if (kill !== 1'b0) $display("FAIL after_branch_kill got %b want 0", kill); else n_pass++;
    endtask

    task automatic test_call_return();
        drive(0, 0, 2'b10, 16'h0, 16'h0100, 1, 16'h0011);
        step();
        n_total++; if (pc !== 16'h0100) $display("FAIL call_pc got %h want 0100", pc); else n_pass++;
        n_total++; if (kill !== 1'b1) $display("FAIL call_kill got %b want 1", kill); else n_pass++;
        n_total++; if (ras_empty !== 1'b0) $display("FAIL call_empty got %b want 0", ras_empty); else n_pass++;
        drive(0, 0, 2'b00, 16'h0, 16'h0, 1, 16'h0);
        step();
        n_total++; if (pc !== 16'h0101) $display("FAIL call_seq_pc got %h want 0101", pc); else n_pass++;
        n_total++; if (kill !== 1'b0) $display("FAIL call_seq_kill got %b want 0", kill); else n_pass++;
        drive(0, 0, 2'b11, 16'h0, 16'h0, 0, 16'h0);
        step();
        n_total++; if (pc !== 16'h0011) $display("FAIL ret_pc got %h want 0011", pc); else n_pass++;
        n_total++; if (kill !== 1'b1) $display("FAIL ret_kill got %b want 1", kill); else n_pass++;
        n_total++; if (ras_empty !== 1'b1) $display("FAIL ret_empty got %b want 1", ras_empty); else n_pass++;
        n_total++; if (ras_err !== 1'b0) $display("FAIL ret_err got %b want 0", ras_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 2'b01, 16'h0200, 16'h0, 0, 16'h0);
        step();
        n_total++; if (kill !== 1'b1) $display("FAIL b2b_kill0 got %b want 1", kill); else n_pass++;
        drive(0, 1, 2'b10, 16'h0, 16'h0300, 0, 16'h0777);
        step();
        n_total++; if (pc !== 16'h0300) $display("FAIL b2b_pc got %h want 0300", pc); else n_pass++;
        n_total++; if (kill !== 1'b1) $display("FAIL b2b_kill1 got %b want 1", kill); else n_pass++;
        n_total++; if (ras_empty !== 1'b1) $display("FAIL b2b_nocall got %b want 1", ras_empty); else n_pass++;
        drive(0, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        step();
        n_total++; if (kill !== 1'b0) $display("FAIL b2b_kill2 got %b want 0", kill); else n_pass++;
    endtask

    task automatic test_underflow();
        drive(0, 0, 2'b01, 16'h0020, 16'h0, 0, 16'h0);
        step();
        drive(0, 0, 2'b11, 16'h0, 16'h0, 0, 16'h0);
        step();
        n_total++; if (pc !== 16'h0021) $display("FAIL uflow_pc got %h want 0021", pc); else n_pass++;
        n_total++; if (kill !== 1'b0) $display("FAIL uflow_kill got %b want 0", kill); else n_pass++;
        n_total++; if (ras_err !== 1'b1) $display("FAIL uflow_err got %b want 1", ras_err); else n_pass++;
        n_total++; if (ras_empty !== 1'b1) $display("FAIL uflow_empty got %b want 1", ras_empty); else n_pass++;
        drive(0, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        step();
        step();
        n_total++; if (ras_err !== 1'b1) $display("FAIL uflow_sticky got %b want 1", ras_err); else n_pass++;
        n_total++; if (pc !== 16'h0023) $display("FAIL uflow_seq_pc got %h want 0023", pc); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_ret [4];
        exp_ret[0] = 16'h0005; exp_ret[1] = 16'h0004; exp_ret[2] = 16'h0003; exp_ret[3] = 16'h0002;
        drive(1, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        step();
        n_total++; if (ras_err !== 1'b0) $display("FAIL oflow_clear got %b want 0", ras_err); else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 2'b10, 16'h0, 16'h1000 + 16'(i), 1, 16'(i));
            step();
            if (i == 4) begin
                n_total++; if (ras_err !== 1'b0) $display("FAIL oflow_err_at4 got %b want 0", ras_err); else n_pass++;
            end
        end
        n_total++; if (ras_err !== 1'b1) $display("FAIL oflow_err got %b want 1", ras_err); else n_pass++;
        n_total++; if (pc !== 16'h1005) $display("FAIL oflow_pc got %h want 1005", pc); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 2'b11, 16'h0, 16'h0, 0, 16'h0);
            step();
            n_total++; if (pc !== exp_ret[i]) $display("FAIL oflow_ret[%0d] got %h want %h", i, pc, exp_ret[i]); else n_pass++;
            n_total++; if (kill !== 1'b1) $display("FAIL oflow_kill[%0d] got %b want 1", i, kill); else n_pass++;
        end
        n_total++; if (ras_empty !== 1'b1) $display("FAIL oflow_empty got %b want 1", ras_empty); else n_pass++;
        n_total++; if (ras_err !== 1'b1) $display("FAIL oflow_err_end got %b want 1", ras_err); else n_pass++;
    endtask

    task automatic test_wrap_and_reset_call();
        drive(0, 0, 2'b01, 16'hFFFF, 16'h0, 0, 16'h0);
        step();
        n_total++; if (pc_plus1 !== 16'h0000) $display("FAIL wrap_plus1 got %h want 0000", pc_plus1); else n_pass++;
        drive(0, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        step();
        n_total++; if (pc !== 16'h0000) $display("FAIL wrap_pc got %h want 0000", pc); else n_pass++;
        n_total++; if (kill !== 1'b0) $display("FAIL wrap_kill got %b want 0", kill); else n_pass++;
        drive(0, 0, 2'b01, 16'h0123, 16'h0, 0, 16'h0);
        step();
        drive(1, 1, 2'b10, 16'h0, 16'h0500, 1, 16'h0abc);
        step();
        n_total++; if (pc !== 16'h0000) $display("FAIL rstcall_pc got %h want 0000", pc); else n_pass++;
        n_total++; if (ras_empty !== 1'b1) $display("FAIL rstcall_empty got %b want 1", ras_empty); else n_pass++;
        n_total++; if (kill !== 1'b0) $display("FAIL rstcall_kill got %b want 0", kill); else n_pass++;
        n_total++; if (ras_err !== 1'b0) $display("FAIL rstcall_err got %b want 0", ras_err); else n_pass++;
        drive(0, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        step();
        n_total++; if (pc !== 16'h0001) $display("FAIL post_reset_pc got %h want 0001", pc); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        drive(1, 0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall_branch();
        test_call_return();
        test_back_to_back();
        test_underflow();
        test_overflow();
        test_wrap_and_reset_call();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
